// File: rtl/map_rom_arbiter_pkg.sv
// map_pkg: shared constants and helpers for the map-ROM access path.
//   MAP_ADDR_W / MAP_DATA_W : map ROM address and pixel widths
//   COL_WALL / COL_DOOR     : collision colours stored in the map
//   req_id_e                : fixed requester slot assignment
//   map_addr()              : pixel (x, y) -> map ROM address ({y>>2, x>>2})
package map_pkg;

    localparam int MAP_ADDR_W = 16;
    localparam int MAP_DATA_W = 12;

    localparam logic [MAP_DATA_W-1:0] COL_WALL = 12'h000;
    localparam logic [MAP_DATA_W-1:0] COL_DOOR = 12'hff0;

    typedef enum int unsigned {
        REQ_PLAYER  = 0,
        REQ_ENEMY0  = 1,
        REQ_ENEMY1  = 2,
        REQ_GRAVITY = 3
    } req_id_e;

    // The map is stored at quarter resolution: 7 bits of row, 9 bits of column.
    function automatic logic [MAP_ADDR_W-1:0] map_addr(input logic [10:0] x,
                                                       input logic [8:0]  y);
        logic [MAP_ADDR_W-1:0] a;
        a = {y[8:2], x[10:2]};
        return a;
    endfunction

endpackage

// File: rtl/map_rom_arbiter_if.sv
// map_rom_arbiter_if: requester-side and ROM-side signals of the map arbiter.
//   req      : per-requester read request (level)
//   addr     : packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt      : one-hot grant
//   rdata    : shared returned pixel
//   rvalid   : one-hot, one-cycle strobe qualifying rdata
//   rom_addr : address towards the map ROM
//   rom_data : read data from the map ROM
// Modports: master = game logic + ROM side, slave = arbiter.
interface map_rom_arbiter_if
    import map_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = MAP_ADDR_W,
    parameter int DATA_W = MAP_DATA_W
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        rvalid;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;

    modport master (
        output req, addr, rom_data,
        input  gnt, rdata, rvalid, rom_addr
    );

    modport slave (
        input  req, addr, rom_data,
        output gnt, rdata, rvalid, rom_addr
    );

endinterface

// File: rtl/map_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector
//   rr_ptr : index searched first; search wraps modulo N_REQ
//   gnt    : one-hot winner (zero when no request)
//   idx    : binary index of the winner
//   any    : at least one request present
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int unsigned        pos;

    always_comb begin
        // Rotate so bit 0 is the rr_ptr requester, then take the first set bit.
        dbl = {req, req} >> rr_ptr;
        rot = dbl[N_REQ-1:0];
        pos = 0;
        any = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                pos = 32'(rr_ptr) + k;
            end
        end
        if (pos >= N_REQ) begin
            pos = pos - N_REQ;
        end
        idx = IDX_W'(pos);
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares one synchronous map ROM among N_REQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : map_rom_arbiter_if.slave (req/addr/gnt/rdata/rvalid/rom_addr/rom_data)
// One grant per cycle, round-robin from rr_ptr. The granted address is
// registered onto rom_addr; an id pipeline of depth ROM_LAT+1 tracks who
// owns each read so the returned pixel is registered into rdata with a
// one-cycle rvalid strobe to its requester (3 cycles after grant for ROM_LAT=1).
// Optional build macro MAP_ARB_PRIO0_EN: requester 0 has absolute priority
// and does not move rr_ptr.
module map_rom_arbiter
    import map_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = MAP_ADDR_W,
    parameter int DATA_W  = MAP_DATA_W,
    parameter int ROM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    map_rom_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = ROM_LAT + 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              ptr_upd;
    logic [IDX_W-1:0]  next_ptr;
    logic [ADDR_W-1:0] sel_addr;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rdata;
    logic [N_REQ-1:0]  rvalid;

    logic [DEPTH-1:0]  pipe_v;
    logic [IDX_W-1:0]  pipe_id [DEPTH];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant is suppressed while in reset so nothing is launched then.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        ptr_upd = 1'b0;
        if (!rst) begin
`ifdef MAP_ARB_PRIO0_EN
            if (bus.req[0]) begin
                gnt[0]  = 1'b1;
                gnt_idx = '0;
                gnt_any = 1'b1;
            end else begin
                gnt     = pick_gnt;
                gnt_idx = pick_idx;
                gnt_any = pick_any;
                ptr_upd = pick_any;
            end
`else
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = pick_any;
            ptr_upd = pick_any;
`endif
        end
    end

    always_comb begin
        next_ptr = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // One-hot grant selects the address; other requesters' addr is ignored.
    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = bus.addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            rom_addr <= '0;
            rdata    <= '0;
            rvalid   <= '0;
            pipe_v   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            if (ptr_upd) begin
                rr_ptr <= next_ptr;
            end
            if (gnt_any) begin
                rom_addr <= sel_addr;
            end
            // A slot is pushed every cycle; empty slots keep rdata steady.
            pipe_v     <= {pipe_v[DEPTH-2:0], gnt_any};
            pipe_id[0] <= gnt_idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_id[i] <= pipe_id[i-1];
            end
            if (pipe_v[DEPTH-1]) begin
                rvalid <= N_REQ'(1) << pipe_id[DEPTH-1];
                rdata  <= bus.rom_data;
            end else begin
                rvalid <= '0;
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rom_addr = rom_addr;
    assign bus.rdata    = rdata;
    assign bus.rvalid   = rvalid;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb_map_rom_arbiter: directed self-checking bench for map_rom_arbiter
// (N_REQ=4, ROM_LAT=1) with a one-cycle synchronous ROM model.
module tb_map_rom_arbiter;
    import map_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    int         ev_cyc[$];
    logic [3:0] ev_rv[$];
    logic [11:0] ev_rd[$];

    map_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    map_rom_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [15:0] a);
        return a[11:0] ^ {a[15:12], 8'hA5};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

    always @(negedge clk) begin
        if (bus.rvalid != 4'b0000) begin
            ev_cyc.push_back(cyc);
            ev_rv.push_back(bus.rvalid);
            ev_rd.push_back(bus.rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_events();
        ev_cyc.delete();
        ev_rv.delete();
        ev_rd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_events();
    endtask

    task automatic drain();
        bus.req = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] a0;
        a0 = map_addr(11'd100, 9'd40);
        bus.addr = {16'h3333, 16'h2222, 16'h1111, a0};
        bus.req = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); end
        n_cmp++; if (bus.rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_rvalid got=%b exp=0000", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 12'h000) begin n_bad++; $display("FAIL rst_rdata got=%h exp=000", bus.rdata); end
        n_cmp++; if (bus.rom_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_rom_addr got=%h exp=0000", bus.rom_addr); end
        @(negedge clk);
        rst = 1'b0;
        clear_events();
        #1;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt got=%b exp=0001", bus.gnt); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_rvalid_c1 got=%b exp=0000", bus.rvalid); end
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL rst_gnt_c1 got=%b exp=0010", bus.gnt); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_rvalid_c2 got=%b exp=0000", bus.rvalid); end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_cmp++; if (bus.rvalid !== 4'b0001) begin n_bad++; $display("FAIL rst_rvalid_c3 got=%b exp=0001", bus.rvalid); end
        n_cmp++; if (bus.rdata !== rom_f(a0)) begin n_bad++; $display("FAIL rst_rdata_c3 got=%h exp=%h", bus.rdata, rom_f(a0)); end
        drain();
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        bus.addr = {16'hFFFF, 16'h1234, 16'hEEEE, 16'hDDDD};
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            bus.req = 4'b0100;
            #1;
            n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt[%0d] got=%b exp=0100", k, bus.gnt); end
            if (k == 0) begin
                n_cmp++; if (bus.rom_addr !== 16'h0000) begin n_bad++; $display("FAIL single_rom_addr0 got=%h exp=0000", bus.rom_addr); end
            end else begin
                n_cmp++; if (bus.rom_addr !== 16'h1234) begin n_bad++; $display("FAIL single_rom_addr[%0d] got=%h exp=1234", k, bus.rom_addr); end
            end
            @(negedge clk);
        end
        bus.req = '0;
        #1;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL single_idle_gnt got=%b exp=0000", bus.gnt); end
        drain();
        n_cmp++; if (bus.rom_addr !== 16'h1234) begin n_bad++; $display("FAIL single_rom_addr_hold got=%h exp=1234", bus.rom_addr); end
        n_cmp++;
        if (ev_cyc.size() !== 4) begin
            n_bad++; $display("FAIL single_nresp got=%0d exp=4", ev_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (ev_cyc[k] !== c0 + k + 3 || ev_rv[k] !== 4'b0100 || ev_rd[k] !== rom_f(16'h1234)) begin
                    n_bad++;
                    $display("FAIL single_resp[%0d] got=cyc%0d/%b/%h exp=cyc%0d/0100/%h",
                             k, ev_cyc[k], ev_rv[k], ev_rd[k], c0 + k + 3, rom_f(16'h1234));
                end
            end
        end
    endtask

    task automatic test_all();
        logic [3:0]  gs [5];
        logic [15:0] a  [4];
        int          ix [5];
        int          c0;
        gs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ix = '{0, 1, 2, 3, 0};
        a  = '{map_addr(11'd8, 9'd4), map_addr(11'd1024, 9'd300),
               map_addr(11'd2047, 9'd511), 16'hBEEF};
        do_reset();
        bus.addr = {a[3], a[2], a[1], a[0]};
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            bus.req = 4'b1111;
            #1;
            n_cmp++; if (bus.gnt !== gs[k]) begin n_bad++; $display("FAIL all_gnt[%0d] got=%b exp=%b", k, bus.gnt, gs[k]); end
            @(negedge clk);
        end
        drain();
        n_cmp++;
        if (ev_cyc.size() !== 5) begin
            n_bad++; $display("FAIL all_nresp got=%0d exp=5", ev_cyc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (ev_cyc[k] !== c0 + k + 3 || ev_rv[k] !== gs[k] || ev_rd[k] !== rom_f(a[ix[k]])) begin
                    n_bad++;
                    $display("FAIL all_resp[%0d] got=cyc%0d/%b/%h exp=cyc%0d/%b/%h",
                             k, ev_cyc[k], ev_rv[k], ev_rd[k], c0 + k + 3, gs[k], rom_f(a[ix[k]]));
                end
            end
        end
    endtask

    task automatic test_withdraw();
        int  c0;
        logic saw1;
        do_reset();
        bus.addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        c0 = cyc;
        bus.req = 4'b1011;
        #1;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wd_gnt0 got=%b exp=0001", bus.gnt); end
        @(negedge clk);
        bus.req = 4'b1001;
        #1;
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL wd_gnt1 got=%b exp=1000", bus.gnt); end
        @(negedge clk); #1;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wd_gnt2 got=%b exp=0001", bus.gnt); end
        @(negedge clk);
        drain();
        saw1 = 1'b0;
        foreach (ev_rv[k]) if (ev_rv[k][1]) saw1 = 1'b1;
        n_cmp++; if (saw1 !== 1'b0) begin n_bad++; $display("FAIL wd_no_rvalid1 got=seen exp=none"); end
        n_cmp++;
        if (ev_cyc.size() !== 3) begin
            n_bad++; $display("FAIL wd_nresp got=%0d exp=3", ev_cyc.size());
        end else begin
            n_cmp++;
            if (ev_rv[1] !== 4'b1000 || ev_rd[1] !== rom_f(16'h4444) || ev_cyc[1] !== c0 + 4) begin
                n_bad++;
                $display("FAIL wd_resp1 got=cyc%0d/%b/%h exp=cyc%0d/1000/%h",
                         ev_cyc[1], ev_rv[1], ev_rd[1], c0 + 4, rom_f(16'h4444));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req = 4'b1111;
        #1;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL mid_gnt_t0 got=%b exp=0001", bus.gnt); end
        @(negedge clk); #1;
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_gnt_t1 got=%b exp=0010", bus.gnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL mid_gnt_in_rst got=%b exp=0000", bus.gnt); end
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.rvalid !== 4'b0000) begin n_bad++; $display("FAIL mid_rvalid[%0d] got=%b exp=0000", k, bus.rvalid); end
            n_cmp++; if (bus.rdata !== 12'h000) begin n_bad++; $display("FAIL mid_rdata[%0d] got=%h exp=000", k, bus.rdata); end
            @(negedge clk);
        end
        drain();
        n_cmp++; if (ev_cyc.size() !== 0) begin n_bad++; $display("FAIL mid_nresp got=%0d exp=0", ev_cyc.size()); end
    endtask

    task automatic test_prio();
        logic [3:0] rq [4];
        logic [3:0] gs [4];
        rq = '{4'b1111, 4'b1111, 4'b1110, 4'b1111};
`ifdef MAP_ARB_PRIO0_EN
        gs = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
        gs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        do_reset();
        bus.addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            bus.req = rq[k];
            #1;
            n_cmp++; if (bus.gnt !== gs[k]) begin n_bad++; $display("FAIL prio_gnt[%0d] got=%b exp=%b", k, bus.gnt, gs[k]); end
            @(negedge clk);
        end
        drain();
        n_cmp++;
        if (ev_cyc.size() !== 4) begin
            n_bad++; $display("FAIL prio_nresp got=%0d exp=4", ev_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (ev_rv[k] !== gs[k]) begin n_bad++; $display("FAIL prio_rv[%0d] got=%b exp=%b", k, ev_rv[k], gs[k]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.addr = '0;
        test_reset();
        test_single();
        test_all();
        test_withdraw();
        test_reset_mid();
        test_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
